serial_adder: RTL and testbench

- Bit-serial adder that wraps a single one-bit full-adder stage with operand shift registers, a carry flip-flop and a result register.
- Accepts two WIDTH-bit operands plus carry-in on a start pulse and processes one bit per clock, LSB first.
- Presents the registered WIDTH-bit sum, carry-out and a one-cycle done pulse.
- Sits directly upstream of the full adder: it sequences operand bits into it and collects its sum/carry back each cycle.

---
 rtl/serial_adder.sv | 170 +++++++++++++++++
 tb/tb_serial_adder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_adder                                               |
// | Description : Bit-serial adder. Captures two WIDTH-bit operands and a    |
// |               carry-in on an accepted start. It then runs one full-adder |
// |               bit per clock, LSB first. The result and the final carry   |
// |               are registered and flagged by a one-cycle done pulse.      |
// | Optional    : SERIAL_ADDER_SUB_EN adds sub_in. When sub_in=1 the block   |
// |               computes a-b by loading ~b and forcing carry-in to 1.      |
// |               In that mode carry_out=1 means no borrow (a >= b).         |
// | Ports       : clk_in     - clock, rising edge                            |
// |               rst_n_in   - asynchronous active-low reset                 |
// |               start_in   - begin an operation (IDLE / DONE exit only)    |
// |               a_in,b_in  - WIDTH-bit operands, captured on start         |
// |               c_in       - carry-in, captured on start                   |
// |               sub_in     - subtract select (SERIAL_ADDER_SUB_EN only)    |
// |               busy_out   - high while bits are being processed           |
// |               done_out   - one-cycle pulse when sum/carry update         |
// |               sum_out    - registered WIDTH-bit result                   |
// |               carry_out  - registered final carry                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_in,
`endif
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             cy_q,     cy_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             carry_q,  carry_d;

  // Values loaded on an accepted start.
  logic [WIDTH-1:0] b_load;
  logic             cy_load;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b = a + ~b + 1; the inverted-B carry-out is the "no borrow" flag.
  assign b_load  = sub_in ? ~b_in : b_in;
  assign cy_load = sub_in ? 1'b1  : c_in;
`else
  assign b_load  = b_in;
  assign cy_load = c_in;
`endif

  // Single full-adder stage working on the current LSBs.
  logic             bit_s;
  logic             bit_co;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum_d    = sum_q;
    carry_d  = carry_q;

    bit_s    = a_sh_q[0] ^ b_sh_q[0] ^ cy_q;
    bit_co   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & cy_q) | (b_sh_q[0] & cy_q);

    // The result enters at the MSB and moves right. After WIDTH steps,
    // bit 0 of the sum has reached bit 0 of the register.
    res_next           = res_sh_q >> 1;
    res_next[WIDTH-1]  = bit_s;

    case (state_q)
      // The edge that leaves DONE is also an acceptance point. This keeps
      // the throughput at one operation every WIDTH+1 cycles.
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start_in) begin
          a_sh_d  = a_in;
          b_sh_d  = b_load;
          cy_d    = cy_load;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        cy_d     = bit_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST_BIT) begin
          // Publish on the same edge that enters DONE.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = res_next;
          carry_d = bit_co;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      cy_q     <= cy_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
    end
  end

  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign sum_out   = sum_q;
  assign carry_out = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_adder                                            |
// | Description : Self-checking bench for serial_adder. It holds an          |
// |               arithmetic reference (a+b+c with a latency counter) that   |
// |               is compared with the DUT every cycle. Directed vectors     |
// |               check literal results, timing and reset abort. A second    |
// |               instance covers the WIDTH=1 case.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub   = 1'b0;
`endif
  logic             busy, done, carry;
  logic [WIDTH-1:0] sum;

  // WIDTH=1 instance
  logic       s1_start = 1'b0;
  logic [0:0] s1_a = '0, s1_b = '0;
  logic       s1_c = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic       s1_sub = 1'b0;
`endif
  logic       s1_busy, s1_done, s1_carry;
  logic [0:0] s1_sum;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH)) u_dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .start_in  (start),
    .a_in      (a),
    .b_in      (b),
    .c_in      (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_in    (sub),
`endif
    .busy_out  (busy),
    .done_out  (done),
    .sum_out   (sum),
    .carry_out (carry)
  );

  serial_adder #(.WIDTH(1)) u_dut_w1 (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .start_in  (s1_start),
    .a_in      (s1_a),
    .b_in      (s1_b),
    .c_in      (s1_c),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_in    (s1_sub),
`endif
    .busy_out  (s1_busy),
    .done_out  (s1_done),
    .sum_out   (s1_sum),
    .carry_out (s1_carry)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the result is plain (W+1)-bit arithmetic and the
  // timing is a countdown of WIDTH busy cycles.
  int               m_left  = 0;
  logic             m_done  = 1'b0;
  logic [WIDTH-1:0] m_sum   = '0;
  logic             m_carry = 1'b0;
  logic [WIDTH:0]   m_tot   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  = 0;
      m_done  = 1'b0;
      m_sum   = '0;
      m_carry = 1'b0;
    end else if (m_left != 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done  = 1'b1;
        m_sum   = m_tot[WIDTH-1:0];
        m_carry = m_tot[WIDTH];
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) m_tot = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        else     m_tot = {1'b0, a} + {1'b0, b}  + (WIDTH+1)'(cin);
`else
        m_tot = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
`endif
        m_left = WIDTH;
      end
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    chk("busy",  {63'd0, busy},  {63'd0, (m_left != 0)});
    chk("done",  {63'd0, done},  {63'd0, m_done});
    chk("sum",   64'(sum),       64'(m_sum));
    chk("carry", {63'd0, carry}, {63'd0, m_carry});
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Wait for done with a bound. n is the number of falling edges after the
  // start edge at which done was first seen.
  task automatic wait_done(input string nm, output int n);
    n = 1;
    while (!done && n < 3 * WIDTH) begin
      step();
      n++;
    end
    if (!done) begin
      bad++;
      $display("FAIL %s: done not seen within %0d cycles", nm, n);
    end
  endtask

  task automatic do_op(input string nm, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic cv, input logic sv,
                       input logic [WIDTH-1:0] exp_sum, input logic exp_c);
    int n;
    step();
    a = av; b = bv; cin = cv; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = sv;
`endif
    step();
    start = 1'b0;
    wait_done(nm, n);
    chk({nm, "_lat"},   64'(n),         64'(WIDTH + 1));
    chk({nm, "_sum"},   64'(sum),       64'(exp_sum));
    chk({nm, "_carry"}, {63'd0, carry}, {63'd0, exp_c});
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
  endtask

  initial begin
    int n, t1, t2, t3, dcount;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t1, t2, t3, dcount;
    step();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sum",  64'(sum),      64'd0);
    step();
    rst_n = 1'b1;
    step();

    do_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    do_op("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    do_op("addffff", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

    // Back-to-back with start held high; the operand changes mid-run.
    step();
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    step(); step(); step();
    a = 8'h10;
    wait_done("b2b1", n);
    t1 = cyc;
    chk("b2b1_sum", 64'(sum), 64'h03);
    a = 8'h01;
    step();
    wait_done("b2b2", n);
    t2 = cyc;
    chk("b2b2_sum", 64'(sum), 64'h03);
    chk("b2b_period1", 64'(t2 - t1), 64'(WIDTH + 1));
    step();
    wait_done("b2b3", n);
    t3 = cyc;
    start = 1'b0;
    chk("b2b3_sum", 64'(sum), 64'h03);
    chk("b2b_period2", 64'(t3 - t2), 64'(WIDTH + 1));
    repeat (WIDTH + 3) step();

    // Reset in mid-operation aborts.
    do_op("add2", 8'h20, 8'h02, 1'b0, 1'b0, 8'h22, 1'b0);
    step();
    a = 8'h0F; b = 8'h01; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  {63'd0, busy},  64'd0);
    chk("abort_done",  {63'd0, done},  64'd0);
    chk("abort_sum",   64'(sum),       64'd0);
    chk("abort_carry", {63'd0, carry}, 64'd0);
    step();
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < WIDTH + 3; i++) begin
      step();
      if (done) dcount++;
    end
    chk("abort_nodone", 64'(dcount), 64'd0);
    do_op("add0f01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op("sub1001", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    do_op("sub0102", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
`endif

    // WIDTH=1: 1+1+1 = 2'b11.
    step();
    s1_a = 1'b1; s1_b = 1'b1; s1_c = 1'b1; s1_start = 1'b1;
    step();
    s1_start = 1'b0;
    chk("w1_busy1", {63'd0, s1_busy}, 64'd1);
    chk("w1_done1", {63'd0, s1_done}, 64'd0);
    step();
    chk("w1_done2", {63'd0, s1_done},  64'd1);
    chk("w1_sum",   64'(s1_sum),       64'd1);
    chk("w1_carry", {63'd0, s1_carry}, 64'd1);
    step();
    chk("w1_done3", {63'd0, s1_done}, 64'd0);

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
